// File: rtl/poly_operand_driver.sv
// Initiator-side sequencer for the polynomial evaluator's serial load port:
// latches A/B/C/X on start, presents each with a go pulse, then captures the result.
module poly_operand_driver #(
  parameter int WIDTH       = 8,
  parameter int GO_CYCLES   = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int RESULT_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] coef_a,
  input  logic [WIDTH-1:0] coef_b,
  input  logic [WIDTH-1:0] coef_c,
  input  logic [WIDTH-1:0] x_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             go_out,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] result_in
);

  localparam int MAX_GG = (GO_CYCLES > GAP_CYCLES) ? GO_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_GG > RESULT_WAIT) ? MAX_GG : RESULT_WAIT;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] GO_LOAD   = CW'(GO_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(RESULT_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GO_HIGH,
    GO_LOW,
    WAIT_RES,
    DONE
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [1:0]       idx, idx_next;
  logic             load, capture, enter_go;
  logic [WIDTH-1:0] op_sel;
  logic [WIDTH-1:0] ops [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          idx_next   = '0;
          cnt_next   = GO_LOAD;
          state_next = GO_HIGH;
        end
      end
      GO_HIGH: begin
        if (cnt == '0) begin
          cnt_next   = GAP_LOAD;
          state_next = GO_LOW;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      GO_LOW: begin
        if (cnt == '0) begin
          if (idx != 2'd3) begin
            idx_next   = idx + 2'd1;
            cnt_next   = GO_LOAD;
            state_next = GO_HIGH;
          end else begin
            cnt_next   = WAIT_LOAD;
            state_next = WAIT_RES;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      WAIT_RES: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  assign enter_go = (state_next == GO_HIGH) && (state != GO_HIGH);
  assign op_sel   = load ? coef_a : ops[idx_next];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      for (int unsigned i = 0; i < 4; i++) ops[i] <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      go_out   <= 1'b0;
      data_out <= '0;
      result   <= '0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
      if (load) begin
        ops[0] <= coef_a;
        ops[1] <= coef_b;
        ops[2] <= coef_c;
        ops[3] <= x_val;
      end
      if (enter_go) data_out <= op_sel;
      if (capture)  result   <= result_in;
      busy   <= (state_next == GO_HIGH) || (state_next == GO_LOW) || (state_next == WAIT_RES);
      go_out <= (state_next == GO_HIGH);
      done   <= (state_next == DONE);
    end
  end

endmodule
